vga_sig_gen_param: RTL and testbench
====================================

// Module: vga_sig_gen_param
// PURPOSE
//  Parametrised VGA timing and pixel-pipeline generator. Produces HS/VS for any mode given porch/pulse
//  timings and an internal pixel-clock-enable divider. Drives a scaled frame-buffer address and maps a
//  multi-bit FB pixel through a colour palette. Compensates FB read latency so sync and colour stay aligned.
// PARAMETERS
//  H_DISP 640 visible pixels; H_FP 16 front porch; H_PW 96 sync pulse; H_BP 48 back porch
//  V_DISP 480 visible lines;  V_FP 10 front porch; V_PW 2 sync pulse;   V_BP 29 back porch
//  PIX_DIV 4: CLK cycles per pixel (>=1; 1 = pixel tick every cycle)
//  SCALE_SHIFT 2: FB pixel = 2^SCALE_SHIFT screen pixels in each axis
//  FB_XW 8, FB_YW 7: FB address X/Y field widths; FB_ADDR width = FB_YW+FB_XW
//  PIX_BITS 1: bits per FB pixel (1..3); palette holds 2^PIX_BITS 8-bit entries
//  HS_POL 0, VS_POL 0: active level of sync pulses
// PORTS
//  CLK          in   1   system clock
//  RESET        in   1   synchronous, active-high reset
//  PALETTE      in   8*2^PIX_BITS  entry i = PALETTE[8*i+:8]
//  FB_ADDR      out  FB_YW+FB_XW   frame-buffer read address, registered
//  FB_DATA      in   PIX_BITS      FB pixel; valid one pixel tick after FB_ADDR
//  PIX_TICK     out  1   one-CLK pulse per pixel (divider wrap)
//  VGA_HS       out  1   horizontal sync
//  VGA_VS       out  1   vertical sync
//  VGA_DE       out  1   display-enable, high on visible pixels
//  ADDRH        out  10  visible x (0..H_DISP-1), 0 when blanked
//  ADDRV        out  10  visible y (0..V_DISP-1), 0 when blanked
//  VGA_COLOUR   out  8   pixel colour, 8'h00 when blanked
//  FRAME_START  out  1   one-CLK pulse aligned with first visible pixel of a frame
// BEHAVIOUR
//  - Divider 0..PIX_DIV-1 on CLK; PIX_TICK=1 on the cycle it equals PIX_DIV-1. All pipeline state
//    below advances only on CLK edges where PIX_TICK=1.
//  - h counter 0..H_TOT-1 (H_TOT=H_PW+H_BP+H_DISP+H_FP), wraps to 0; v counter 0..V_TOT-1 increments
//    when h wraps, wraps to 0 when both at max. Widths $clog2 of totals.
//  - Line order: sync [0,H_PW), back porch, visible [H_PW+H_BP, H_PW+H_BP+H_DISP), front porch. Same
//    for vertical. Visible = h visible AND v visible.
//  - Stage 1 (tick n+1 for counter position n): FB_ADDR <= {y>>SCALE_SHIFT, x>>SCALE_SHIFT} truncated to
//    FB_YW/FB_XW, x/y = position within visible area; FB_ADDR <= 0 when not visible. Sync/visible
//    flags, x, y delayed into stage 1.
//  - Stage 2 (tick n+2): VGA_HS = HS_POL when h in sync else ~HS_POL; VGA_VS likewise; VGA_DE, ADDRH,
//    ADDRV from stage-1 copies; VGA_COLOUR = PALETTE[8*FB_DATA+:8] if visible else 8'h00.
//    Latency: counter -> FB_ADDR 1 tick; counter -> all VGA outputs 2 ticks, all mutually aligned.
//  - FRAME_START: asserted for exactly the one CLK cycle on which stage 2 registers x=0,y=0 visible.
//  - Reset (any time, incl. mid-frame): divider, h, v = 0; pipeline flushed; FB_ADDR=0, VGA_HS=~HS_POL,
//    VGA_VS=~VS_POL, VGA_DE=0, ADDRH=ADDRV=0, VGA_COLOUR=0, FRAME_START=0, PIX_TICK=0. First tick after
//    release is PIX_DIV cycles later; frame restarts at h=v=0 (sync pulse).
//  - RESET wins over PIX_TICK on the same edge. FB_DATA out-of-range bits impossible (width exact).
//  - PALETTE sampled at stage 2 each tick; changes take effect on the next visible pixel.
// TESTING
//  1 Defaults, release reset -> PIX_TICK every 4 CLK; VGA_HS low 384 CLK, period 3200 CLK; VS low 2 lines,
//    frame 521*3200 CLK.
//  2 Defaults -> VGA_DE high exactly 640 ticks/line, 480 lines/frame; first DE at h=144+2 ticks, v=31.
//  3 FB model returns addr[0]; check FB_ADDR=0 at (x0,y0), 1 at (x4,y0), 256 at (x0,y4); PALETTE=16'hE01C
//    -> COLOUR alternates 8'h1C/8'hE0 every 4 pixels, 8'h00 in porches.
//  4 RESET pulsed 1 CLK mid-line (v=200,h=400) -> all outputs at reset values next edge; HS edge
//    re-timed from release; FRAME_START next fires one full frame of blanking later.
//  5 PIX_DIV=1, PIX_BITS=2, HS_POL=VS_POL=1, small mode (H 8/2/2/2, V 4/1/1/1) -> HS high 2 CLK of 14,
//    COLOUR = PALETTE entry 0..3 per FB_DATA, FRAME_START once per 98 CLK.

Source files
------------

// File: rtl/vga_sig_gen_param.sv
// Parametrised VGA timing generator with a two-stage pixel pipeline:
// stage 1 issues the frame-buffer address, stage 2 registers sync, DE and palette colour.
`timescale 1ns/1ps
module vga_sig_gen_param #(
  parameter int unsigned H_DISP      = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_PW        = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_DISP      = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_PW        = 2,
  parameter int unsigned V_BP        = 29,
  parameter int unsigned PIX_DIV     = 4,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned FB_XW       = 8,
  parameter int unsigned FB_YW       = 7,
  parameter int unsigned PIX_BITS    = 1,
  parameter logic        HS_POL      = 1'b0,
  parameter logic        VS_POL      = 1'b0
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [8*(2**PIX_BITS)-1:0]    PALETTE,
  output logic [FB_YW+FB_XW-1:0]        FB_ADDR,
  input  logic [PIX_BITS-1:0]           FB_DATA,
  output logic                          PIX_TICK,
  output logic                          VGA_HS,
  output logic                          VGA_VS,
  output logic                          VGA_DE,
  output logic [9:0]                    ADDRH,
  output logic [9:0]                    ADDRV,
  output logic [7:0]                    VGA_COLOUR,
  output logic                          FRAME_START
);

  localparam int unsigned H_TOT = H_PW + H_BP + H_DISP + H_FP;
  localparam int unsigned V_TOT = V_PW + V_BP + V_DISP + V_FP;
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);
  localparam int unsigned DW    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned H_VS  = H_PW + H_BP;
  localparam int unsigned H_VE  = H_VS + H_DISP;
  localparam int unsigned V_VS  = V_PW + V_BP;
  localparam int unsigned V_VE  = V_VS + V_DISP;

  localparam logic [DW-1:0] DIV_MAX = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0] H_MAX   = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_MAX   = VW'(V_TOT - 1);

  logic [DW-1:0]    div;
  logic [DW-1:0]    div_nxt;
  logic [HW-1:0]    h;
  logic [VW-1:0]    v;
  logic [31:0]      x32;
  logic [31:0]      y32;
  logic [FB_XW-1:0] fb_x;
  logic [FB_YW-1:0] fb_y;
  logic             h_vis;
  logic             v_vis;
  logic             vis_c;
  logic             hs_c;
  logic             vs_c;
  logic             s1_vis;
  logic             s1_hs;
  logic             s1_vs;
  logic [9:0]       s1_x;
  logic [9:0]       s1_y;

  always_comb begin
    div_nxt = (div == DIV_MAX) ? '0 : div + DW'(1);
  end

  // PIX_TICK is registered alongside the divider so it reads 0 while the divider sits in reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div      <= '0;
      PIX_TICK <= 1'b0;
    end else begin
      div      <= div_nxt;
      PIX_TICK <= (div_nxt == DIV_MAX);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      h <= '0;
      v <= '0;
    end else if (PIX_TICK) begin
      if (h == H_MAX) begin
        h <= '0;
        v <= (v == V_MAX) ? '0 : v + VW'(1);
      end else begin
        h <= h + HW'(1);
      end
    end
  end

  always_comb begin
    x32   = 32'(h) - H_VS;
    y32   = 32'(v) - V_VS;
    fb_x  = FB_XW'(x32 >> SCALE_SHIFT);
    fb_y  = FB_YW'(y32 >> SCALE_SHIFT);
    h_vis = (32'(h) >= H_VS) && (32'(h) < H_VE);
    v_vis = (32'(v) >= V_VS) && (32'(v) < V_VE);
    vis_c = h_vis && v_vis;
    hs_c  = (32'(h) < H_PW);
    vs_c  = (32'(v) < V_PW);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      FB_ADDR <= '0;
      s1_vis  <= 1'b0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_x    <= '0;
      s1_y    <= '0;
    end else if (PIX_TICK) begin
      FB_ADDR <= vis_c ? {fb_y, fb_x} : '0;
      s1_vis  <= vis_c;
      s1_hs   <= hs_c;
      s1_vs   <= vs_c;
      s1_x    <= vis_c ? x32[9:0] : '0;
      s1_y    <= vis_c ? y32[9:0] : '0;
    end
  end

  // FB_DATA answers the stage-1 address, so colour lines up with the stage-1 copies.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      VGA_DE      <= 1'b0;
      ADDRH       <= '0;
      ADDRV       <= '0;
      VGA_COLOUR  <= 8'h00;
      FRAME_START <= 1'b0;
    end else begin
      FRAME_START <= 1'b0;
      if (PIX_TICK) begin
        VGA_HS      <= s1_hs ? HS_POL : ~HS_POL;
        VGA_VS      <= s1_vs ? VS_POL : ~VS_POL;
        VGA_DE      <= s1_vis;
        ADDRH       <= s1_x;
        ADDRV       <= s1_y;
        VGA_COLOUR  <= s1_vis ? PALETTE[{FB_DATA, 3'b000} +: 8] : 8'h00;
        FRAME_START <= s1_vis && (s1_x == '0) && (s1_y == '0);
      end
    end
  end

endmodule

// File: tb/tb_vga_sig_gen_param.sv
// Bench for vga_sig_gen_param: a reduced 4-clock-per-pixel mode and the tiny 1-clock mode,
// checked every cycle against a raster-position model plus table vectors and timing sequences.
`timescale 1ns/1ps
module tb_vga_sig_gen_param;

  typedef struct {
    int p, hpw, hbp, hdisp, hfp, vpw, vbp, vdisp, vfp, shift, xw, yw, pbits;
    bit hpol, vpol;
  } mode_t;

  typedef struct {
    logic [15:0] pal;
    int x;
    int y;
    int exp_addr;
    int exp_col;
  } vec_t;

  localparam int S_TICK = 0;
  localparam int S_HS   = 1;
  localparam int S_VS   = 2;
  localparam int S_DE   = 3;
  localparam int S_FS   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1;
  logic        rst_b = 1'b1;
  logic [15:0] pal_a = 16'hE01C;
  logic [31:0] pal_b = 32'h44332211;
  logic [14:0] fb_addr_a;
  logic        fb_data_a;
  logic [4:0]  fb_addr_b;
  logic [1:0]  fb_data_b;
  logic        tick_a, hs_a, vs_a, de_a, fs_a;
  logic        tick_b, hs_b, vs_b, de_b, fs_b;
  logic [9:0]  ah_a, av_a, ah_b, av_b;
  logic [7:0]  col_a, col_b;

  assign fb_data_a = fb_addr_a[0];
  assign fb_data_b = fb_addr_b[1:0];

  vga_sig_gen_param #(
    .H_DISP(16), .H_FP(2), .H_PW(4), .H_BP(3),
    .V_DISP(12), .V_FP(1), .V_PW(2), .V_BP(2),
    .PIX_DIV(4), .SCALE_SHIFT(2), .FB_XW(8), .FB_YW(7), .PIX_BITS(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_a (
    .CLK(clk), .RESET(rst_a), .PALETTE(pal_a), .FB_ADDR(fb_addr_a), .FB_DATA(fb_data_a),
    .PIX_TICK(tick_a), .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_DE(de_a),
    .ADDRH(ah_a), .ADDRV(av_a), .VGA_COLOUR(col_a), .FRAME_START(fs_a)
  );

  vga_sig_gen_param #(
    .H_DISP(8), .H_FP(2), .H_PW(2), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_PW(1), .V_BP(1),
    .PIX_DIV(1), .SCALE_SHIFT(0), .FB_XW(3), .FB_YW(2), .PIX_BITS(2),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_b (
    .CLK(clk), .RESET(rst_b), .PALETTE(pal_b), .FB_ADDR(fb_addr_b), .FB_DATA(fb_data_b),
    .PIX_TICK(tick_b), .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_DE(de_b),
    .ADDRH(ah_b), .ADDRV(av_b), .VGA_COLOUR(col_b), .FRAME_START(fs_b)
  );

  int o_addr[2], o_x[2], o_y[2], o_col[2];
  bit o_tick[2], o_hs[2], o_vs[2], o_de[2], o_fs[2];

  always_comb begin
    o_addr[0] = int'(fb_addr_a); o_x[0] = int'(ah_a); o_y[0] = int'(av_a); o_col[0] = int'(col_a);
    o_tick[0] = tick_a; o_hs[0] = hs_a; o_vs[0] = vs_a; o_de[0] = de_a; o_fs[0] = fs_a;
    o_addr[1] = int'(fb_addr_b); o_x[1] = int'(ah_b); o_y[1] = int'(av_b); o_col[1] = int'(col_b);
    o_tick[1] = tick_b; o_hs[1] = hs_b; o_vs[1] = vs_b; o_de[1] = de_b; o_fs[1] = fs_b;
  end

  mode_t md[2];
  int    k[2];        // non-reset clock edges since the last reset edge
  int    ticks[2];    // pixel ticks consumed since reset
  int    exp_col[2];
  bit    exp_fs[2];
  bit    mon_en = 1'b0;
  int    checks = 0;
  int    errors = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d (0x%0h) want %0d (0x%0h)", name, $time, act, act, exp, exp);
    end
  endfunction

  function automatic int htot(mode_t m);
    return m.hpw + m.hbp + m.hdisp + m.hfp;
  endfunction

  function automatic int frame_len(mode_t m);
    return htot(m) * (m.vpw + m.vbp + m.vdisp + m.vfp);
  endfunction

  // Raster index n counts pixels from the start of line 0's sync pulse.
  function automatic void locate(mode_t m, int n, output int h, output int v,
                                 output bit vis, output int x, output int y);
    h   = n % htot(m);
    v   = n / htot(m);
    x   = h - (m.hpw + m.hbp);
    y   = v - (m.vpw + m.vbp);
    vis = (x >= 0) && (x < m.hdisp) && (y >= 0) && (y < m.vdisp);
  endfunction

  function automatic int fb_addr_at(mode_t m, int n);
    int h, v, x, y;
    bit vis;
    locate(m, n, h, v, vis, x, y);
    if (!vis) return 0;
    return (((y >> m.shift) % (1 << m.yw)) << m.xw) + ((x >> m.shift) % (1 << m.xw));
  endfunction

  function automatic bit tick_due(int d);
    return (k[d] >= 1) && (k[d] % md[d].p == md[d].p - 1);
  endfunction

  task automatic model_edge(int d, bit rst, logic [31:0] pal);
    int h, v, x, y, n, ent;
    bit vis;
    if (rst) begin
      k[d] = 0; ticks[d] = 0; exp_col[d] = 0; exp_fs[d] = 1'b0;
    end else begin
      exp_fs[d] = 1'b0;
      if (tick_due(d)) begin
        ticks[d]++;
        if (ticks[d] >= 2) begin
          n = (ticks[d] - 2) % frame_len(md[d]);
          locate(md[d], n, h, v, vis, x, y);
          ent = fb_addr_at(md[d], n) % (1 << md[d].pbits);
          exp_col[d] = vis ? int'((pal >> (8 * ent)) & 32'hFF) : 0;
          exp_fs[d]  = vis && (x == 0) && (y == 0);
        end
      end
      k[d]++;
    end
  endtask

  task automatic check_dut(int d);
    int h, v, x, y, e_addr, e_x, e_y;
    bit vis, e_hs, e_vs, e_de;
    mode_t m;
    m = md[d];
    e_addr = (ticks[d] >= 1) ? fb_addr_at(m, (ticks[d] - 1) % frame_len(m)) : 0;
    e_hs = ~m.hpol; e_vs = ~m.vpol; e_de = 1'b0; e_x = 0; e_y = 0;
    if (ticks[d] >= 2) begin
      locate(m, (ticks[d] - 2) % frame_len(m), h, v, vis, x, y);
      e_hs = (h < m.hpw) ? m.hpol : ~m.hpol;
      e_vs = (v < m.vpw) ? m.vpol : ~m.vpol;
      e_de = vis;
      if (vis) begin e_x = x; e_y = y; end
    end
    chk($sformatf("d%0d_tick", d),   int'(o_tick[d]), int'(tick_due(d)));
    chk($sformatf("d%0d_fbaddr", d), o_addr[d], e_addr);
    chk($sformatf("d%0d_hs", d),     int'(o_hs[d]), int'(e_hs));
    chk($sformatf("d%0d_vs", d),     int'(o_vs[d]), int'(e_vs));
    chk($sformatf("d%0d_de", d),     int'(o_de[d]), int'(e_de));
    chk($sformatf("d%0d_addrh", d),  o_x[d], e_x);
    chk($sformatf("d%0d_addrv", d),  o_y[d], e_y);
    chk($sformatf("d%0d_colour", d), o_col[d], exp_col[d]);
    chk($sformatf("d%0d_fstart", d), int'(o_fs[d]), int'(exp_fs[d]));
  endtask

  always @(posedge clk) begin
    model_edge(0, rst_a, {16'h0000, pal_a});
    model_edge(1, rst_b, pal_b);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check_dut(0);
      check_dut(1);
    end
  end

  function automatic bit sigv(int d, int sel);
    case (sel)
      S_TICK:  return o_tick[d];
      S_HS:    return o_hs[d];
      S_VS:    return o_vs[d];
      S_DE:    return o_de[d];
      default: return o_fs[d];
    endcase
  endfunction

  task automatic wait_for(int d, int sel, bit lvl, int budget, output int n);
    n = 0;
    while (sigv(d, sel) != lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sigv(d, sel) != lvl) begin
      errors++;
      $display("FAIL wait_d%0d_sig%0d: still %0d after %0d cycles, want %0d", d, sel, sigv(d, sel), budget, lvl);
    end
  endtask

  initial begin
    int n1, n2, cnt, lines, prev_addr;
    bit prev_de, hit;
    vec_t tbl[6];

    md[0] = '{p:4, hpw:4, hbp:3, hdisp:16, hfp:2, vpw:2, vbp:2, vdisp:12, vfp:1,
              shift:2, xw:8, yw:7, pbits:1, hpol:1'b0, vpol:1'b0};
    md[1] = '{p:1, hpw:2, hbp:2, hdisp:8, hfp:2, vpw:1, vbp:1, vdisp:4, vfp:1,
              shift:0, xw:3, yw:2, pbits:2, hpol:1'b1, vpol:1'b1};

    // FB_DATA = FB_ADDR[0] in mode A: x/y fields step every 4 screen pixels.
    tbl[0] = '{16'hE01C,  0,  0,   0, 8'h1C};
    tbl[1] = '{16'hE01C,  4,  0,   1, 8'hE0};
    tbl[2] = '{16'hE01C,  0,  4, 256, 8'h1C};
    tbl[3] = '{16'h55AA,  5,  4, 257, 8'h55};
    tbl[4] = '{16'h55AA, 15, 11, 515, 8'h55};
    tbl[5] = '{16'h55AA,  3,  7, 256, 8'hAA};

    repeat (3) @(negedge clk);
    chk("a_rst_fbaddr", o_addr[0], 0);
    chk("a_rst_hs", int'(o_hs[0]), 1);
    chk("a_rst_vs", int'(o_vs[0]), 1);
    chk("a_rst_de", int'(o_de[0]), 0);
    chk("a_rst_colour", o_col[0], 0);
    chk("a_rst_tick", int'(o_tick[0]), 0);
    chk("b_rst_hs", int'(o_hs[1]), 0);
    chk("b_rst_vs", int'(o_vs[1]), 0);
    chk("b_rst_tick", int'(o_tick[1]), 0);
    chk("b_rst_fstart", int'(o_fs[1]), 0);

    mon_en = 1'b1;
    rst_a = 1'b0;
    rst_b = 1'b0;

    wait_for(0, S_TICK, 1'b1, 10, n1);
    wait_for(0, S_TICK, 1'b0, 10, n1);
    wait_for(0, S_TICK, 1'b1, 10, n2);
    chk("a_tick_width", n1, 1);
    chk("a_tick_period", n1 + n2, 4);
    cnt = 0;
    repeat (20) begin @(negedge clk); cnt += int'(o_tick[1]); end
    chk("b_tick_always", cnt, 20);

    wait_for(0, S_HS, 1'b0, 300, n1);
    wait_for(0, S_HS, 1'b1, 300, n1);
    wait_for(0, S_HS, 1'b0, 300, n2);
    chk("a_hs_low", n1, 16);
    chk("a_hs_period", n1 + n2, 100);
    wait_for(1, S_HS, 1'b1, 50, n1);
    wait_for(1, S_HS, 1'b0, 50, n1);
    wait_for(1, S_HS, 1'b1, 50, n2);
    chk("b_hs_high", n1, 2);
    chk("b_hs_period", n1 + n2, 14);
    wait_for(1, S_VS, 1'b1, 200, n1);
    wait_for(1, S_VS, 1'b0, 200, n1);
    wait_for(1, S_VS, 1'b1, 200, n2);
    chk("b_vs_high", n1, 14);
    chk("b_vs_period", n1 + n2, 98);
    wait_for(0, S_VS, 1'b0, 2000, n1);
    wait_for(0, S_VS, 1'b1, 2000, n1);
    wait_for(0, S_VS, 1'b0, 2000, n2);
    chk("a_vs_low", n1, 200);
    chk("a_vs_period", n1 + n2, 1700);

    wait_for(1, S_FS, 1'b1, 200, n1);
    wait_for(1, S_FS, 1'b0, 200, n1);
    wait_for(1, S_FS, 1'b1, 200, n2);
    chk("b_fs_width", n1, 1);
    chk("b_fs_period", n1 + n2, 98);
    chk("b_col_x0", o_col[1], 8'h11);
    @(negedge clk); chk("b_col_x1", o_col[1], 8'h22);
    @(negedge clk); chk("b_col_x2", o_col[1], 8'h33);
    @(negedge clk); chk("b_col_x3", o_col[1], 8'h44);

    wait_for(0, S_FS, 1'b1, 2000, n1);
    cnt = 0; lines = 0; prev_de = 1'b1;
    repeat (1700) begin
      @(negedge clk);
      if (o_de[0]) cnt++;
      if (o_de[0] && !prev_de) lines++;
      prev_de = o_de[0];
    end
    chk("a_de_cycles_frame", cnt, 768);
    chk("a_de_lines_frame", lines, 12);
    chk("a_fs_period", int'(o_fs[0]), 1);
    wait_for(0, S_DE, 1'b0, 200, n1);
    chk("a_de_line_width", n1, 64);

    for (int i = 0; i < 6; i++) begin
      pal_a = tbl[i].pal;
      n1 = 0;
      while (o_de[0] && o_x[0] == tbl[i].x && o_y[0] == tbl[i].y && n1 < 10) begin
        @(negedge clk);
        n1++;
      end
      n1 = 0;
      prev_addr = o_addr[0];
      hit = o_de[0] && o_x[0] == tbl[i].x && o_y[0] == tbl[i].y;
      while (!hit && n1 < 2000) begin
        prev_addr = o_addr[0];
        @(negedge clk);
        n1++;
        hit = o_de[0] && o_x[0] == tbl[i].x && o_y[0] == tbl[i].y;
      end
      if (!hit) begin
        errors++;
        $display("FAIL tbl%0d_wait: pixel (%0d,%0d) not shown within 2000 cycles", i, tbl[i].x, tbl[i].y);
      end else begin
        chk($sformatf("tbl%0d_fbaddr", i), prev_addr, tbl[i].exp_addr);
        chk($sformatf("tbl%0d_colour", i), o_col[0], tbl[i].exp_col);
      end
    end

    n1 = 0;
    while (!(o_de[0] && o_x[0] == 8 && o_y[0] == 6) && n1 < 2000) begin
      @(negedge clk);
      n1++;
    end
    rst_a = 1'b1;
    @(negedge clk);
    chk("a_midrst_fbaddr", o_addr[0], 0);
    chk("a_midrst_hs", int'(o_hs[0]), 1);
    chk("a_midrst_de", int'(o_de[0]), 0);
    chk("a_midrst_addrh", o_x[0], 0);
    chk("a_midrst_colour", o_col[0], 0);
    chk("a_midrst_tick", int'(o_tick[0]), 0);
    rst_a = 1'b0;
    wait_for(0, S_HS, 1'b0, 100, n1);
    wait_for(0, S_FS, 1'b1, 2000, n2);
    chk("a_hs_after_release", n1, 8);
    chk("a_fs_after_release", n1 + n2, 436);

    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) pal_a = 16'($urandom);
      if ($urandom_range(0, 39) == 0) pal_b = $urandom;
      if (rst_a) rst_a = 1'b0;
      else if ($urandom_range(0, 999) == 0) rst_a = 1'b1;
      if (rst_b) rst_b = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst_b = 1'b1;
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (5) @(negedge clk);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
